// File: rtl/sec_tick_ctrl.sv
// Seconds-chain driver: divides clk to a one-second tick and issues inc_sec
// plus carry increments for the seconds-tens and minutes-units registers.
module sec_tick_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic step,
  input  logic set_any,
  input  logic sec_U_hit9,
  input  logic sec_T_hit5,
  output logic inc_sec,
  output logic inc_sec_T,
  output logic inc_min,
  output logic running
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          step_q;
  logic          tick;

  // Carry flags are sampled with the tick, before the digit registers move.
  always_comb begin
    tick = 1'b0;
    if (!set_any) begin
      if (state == RUNNING)
        tick = (presc == TC);
      else
        tick = step && !step_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PAUSED;
      presc     <= '0;
      step_q    <= 1'b0;
      inc_sec   <= 1'b0;
      inc_sec_T <= 1'b0;
      inc_min   <= 1'b0;
      running   <= 1'b0;
    end else begin
      step_q    <= step;
      inc_sec   <= tick;
      inc_sec_T <= tick && sec_U_hit9;
      inc_min   <= tick && sec_U_hit9 && sec_T_hit5;

      // The prescaler holds across a pause so a resumed second is not lengthened.
      if (set_any)
        presc <= '0;
      else if (state == RUNNING)
        presc <= (presc == TC) ? '0 : presc + 1'b1;

      state   <= run ? RUNNING : PAUSED;
      running <= run;
    end
  end

endmodule
